// File: rtl/lsu_defer_sched.sv
// lsu_defer_sched: issue-stage scheduler between the scoreboard issue port
// and issue_read_operands. When the LSU is busy one LOAD/STORE is parked in
// a single slot so that independent ALU/MULT ops can issue ahead of it.
// Ports: clk_i/rst_i (sync, active-high); flush_i, debug_req_i, en_i,
// lsu_ready_i control; issue_entry_*_i / is_ctrl_flow_i / issue_instr_ack_o
// face the scoreboard; issue_entry_*_o / is_ctrl_flow_o / issue_instr_ack_i
// face the issue stage; held_o = slot occupied; bypass_cnt_o = overtakes.

package ariane_pkg;
  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW,
    MULT, CSR, FPU, FPU_VEC
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
  } scoreboard_entry_t;
endpackage

module lsu_defer_sched
  import ariane_pkg::*;
#(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned MAX_BYPASS = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              debug_req_i,
  input  logic              en_i,
  input  logic              lsu_ready_i,
  input  scoreboard_entry_t issue_entry_i,
  input  logic              issue_entry_valid_i,
  input  logic              is_ctrl_flow_i,
  output logic              issue_instr_ack_o,
  output scoreboard_entry_t issue_entry_o,
  output logic              issue_entry_valid_o,
  output logic              is_ctrl_flow_o,
  input  logic              issue_instr_ack_i,
  output logic              held_o,
  output logic [CNT_W-1:0]  bypass_cnt_o
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic [7:0] BYP_LIM  = 8'(MAX_BYPASS);

  typedef enum logic [1:0] {PASS, HOLD, DRAIN} state_e;

  state_e            state_q, state_d;
  scoreboard_entry_t slot_q, slot_d;
  logic              slot_cf_q, slot_cf_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        byp_q, byp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  scoreboard_entry_t in_e;
  logic is_mem, fu_ok, rs_hit, rd_hit;
  logic indep, drain, park, bypass;

  assign in_e   = issue_entry_i;
  assign is_mem = in_e.fu inside {LOAD, STORE};
  assign fu_ok  = !(in_e.fu inside
    {LOAD, STORE, CTRL_FLOW, CSR, FPU, FPU_VEC});

  // x0 never creates a dependency in either direction
  assign rs_hit = (slot_q.rd != 5'd0) &&
                  ((in_e.rs1 == slot_q.rd) ||
                   (in_e.rs2 == slot_q.rd));
  assign rd_hit = (in_e.rd != 5'd0) &&
                  ((in_e.rd == slot_q.rs1) ||
                   (in_e.rd == slot_q.rs2) ||
                   (in_e.rd == slot_q.rd));

  assign indep = fu_ok & ~is_ctrl_flow_i & ~rs_hit & ~rd_hit;

  assign drain = lsu_ready_i | (hold_q >= HOLD_LIM) |
                 (byp_q >= BYP_LIM) | debug_req_i | ~en_i;

  assign park = (state_q == PASS) & issue_entry_valid_i &
                is_mem & ~lsu_ready_i & en_i &
                ~debug_req_i & ~flush_i;

  assign bypass = (state_q == HOLD) & ~drain &
                  issue_entry_valid_i & indep & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= PASS;
      slot_q    <= '0;
      slot_cf_q <= 1'b0;
      hold_q    <= '0;
      byp_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      slot_cf_q <= slot_cf_d;
      hold_q    <= hold_d;
      byp_q     <= byp_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    slot_cf_d = slot_cf_q;
    hold_d    = hold_q;
    byp_d     = byp_q;
    cnt_d     = cnt_q;
    if (flush_i) begin
      state_d   = PASS;
      slot_d    = '0;
      slot_cf_d = 1'b0;
      hold_d    = '0;
      byp_d     = '0;
    end else begin
      unique case (state_q)
        PASS: begin
          if (park) begin
            state_d   = HOLD;
            slot_d    = in_e;
            slot_cf_d = is_ctrl_flow_i;
            hold_d    = '0;
            byp_d     = '0;
          end
        end
        HOLD: begin
          if (hold_q != 8'hff) hold_d = hold_q + 8'd1;
          if (bypass) begin
            if (issue_instr_ack_i) begin
              if (byp_q != 8'hff) byp_d = byp_q + 8'd1;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (issue_instr_ack_i) begin
            state_d   = PASS;
            slot_d    = '0;
            slot_cf_d = 1'b0;
          end else begin
            // the slot is now visible; it may not be withdrawn
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (issue_instr_ack_i) begin
            state_d   = PASS;
            slot_d    = '0;
            slot_cf_d = 1'b0;
          end
        end
        default: state_d = PASS;
      endcase
    end
  end

  always_comb begin
    issue_entry_o       = in_e;
    is_ctrl_flow_o      = is_ctrl_flow_i;
    issue_entry_valid_o = 1'b0;
    issue_instr_ack_o   = 1'b0;
    if (!rst_i && flush_i) begin
      issue_instr_ack_o = issue_instr_ack_i;
    end else if (!rst_i) begin
      unique case (state_q)
        PASS: begin
          if (park) begin
            issue_instr_ack_o = 1'b1;
          end else begin
            issue_entry_valid_o = issue_entry_valid_i;
            issue_instr_ack_o   = issue_instr_ack_i;
          end
        end
        HOLD: begin
          if (bypass) begin
            issue_entry_valid_o = 1'b1;
            issue_instr_ack_o   = issue_instr_ack_i;
          end else begin
            issue_entry_o       = slot_q;
            is_ctrl_flow_o      = slot_cf_q;
            issue_entry_valid_o = 1'b1;
          end
        end
        DRAIN: begin
          issue_entry_o       = slot_q;
          is_ctrl_flow_o      = slot_cf_q;
          issue_entry_valid_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign held_o       = ~rst_i & (state_q != PASS);
  assign bypass_cnt_o = rst_i ? '0 : cnt_q;

endmodule

// File: tb/tb_lsu_defer_sched.sv
// tb_lsu_defer_sched: directed and random checks of lsu_defer_sched
// against a transaction-level model of the deferral slot.

module tb_lsu_defer_sched;
  import ariane_pkg::*;

  localparam int MH = 8;
  localparam int MB = 4;
  localparam int CW = 32;
  localparam int EW = $bits(scoreboard_entry_t);
  localparam int VW = 3 + CW + 1 + EW;

  logic clk_i = 1'b0;
  logic rst_i, flush_i, debug_req_i, en_i, lsu_ready_i;
  logic issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i;
  scoreboard_entry_t issue_entry_i, issue_entry_o;
  logic issue_instr_ack_o, issue_entry_valid_o;
  logic is_ctrl_flow_o, held_o;
  logic [CW-1:0] bypass_cnt_o;

  always #5 clk_i = ~clk_i;

  lsu_defer_sched #(
    .MAX_HOLD(MH), .MAX_BYPASS(MB), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .debug_req_i(debug_req_i),
    .en_i(en_i),
    .lsu_ready_i(lsu_ready_i),
    .issue_entry_i(issue_entry_i),
    .issue_entry_valid_i(issue_entry_valid_i),
    .is_ctrl_flow_i(is_ctrl_flow_i),
    .issue_instr_ack_o(issue_instr_ack_o),
    .issue_entry_o(issue_entry_o),
    .issue_entry_valid_o(issue_entry_valid_o),
    .is_ctrl_flow_o(is_ctrl_flow_o),
    .issue_instr_ack_i(issue_instr_ack_i),
    .held_o(held_o),
    .bypass_cnt_o(bypass_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    bit rst, flush, dbg, en, rdy, vld, cf, ack;
    scoreboard_entry_t e;
  } step_t;

  // reference model: is a memory op waiting, has it been shown
  bit                m_parked = 0;
  bit                m_shown  = 0;
  scoreboard_entry_t m_slot   = '0;
  bit                m_slot_cf = 0;
  int                m_age  = 0;
  int                m_nbyp = 0;
  logic [CW-1:0]     m_cnt  = '0;

  bit e_ack, e_valid, e_held, e_cf, e_byp, e_park;
  scoreboard_entry_t e_entry;
  logic [CW-1:0] e_cnt;

  function automatic bit may_overtake(scoreboard_entry_t x,
                                      bit cf,
                                      scoreboard_entry_t s);
    bit ok;
    ok = !(x.fu inside {LOAD, STORE, CTRL_FLOW, CSR, FPU, FPU_VEC});
    if (cf) ok = 0;
    if (x.rd != 0) begin
      if (x.rd == s.rs1) ok = 0;
      if (x.rd == s.rs2) ok = 0;
      if (x.rd == s.rd)  ok = 0;
    end
    if (s.rd != 0 && (x.rs1 == s.rd || x.rs2 == s.rd)) ok = 0;
    return ok;
  endfunction

  function automatic void predict();
    bit rel;
    e_byp = 0; e_park = 0;
    e_entry = issue_entry_i; e_cf = is_ctrl_flow_i;
    e_valid = 0; e_ack = 0;
    e_held = m_parked; e_cnt = m_cnt;
    if (rst_i) begin
      e_held = 0; e_cnt = '0;
    end else if (flush_i) begin
      e_ack = issue_instr_ack_i;
    end else if (!m_parked) begin
      if (issue_entry_valid_i && !lsu_ready_i && en_i &&
          !debug_req_i && issue_entry_i.fu inside {LOAD, STORE}) begin
        e_park = 1; e_ack = 1;
      end else begin
        e_valid = issue_entry_valid_i;
        e_ack = issue_instr_ack_i;
      end
    end else begin
      rel = m_shown || lsu_ready_i || m_age >= MH ||
            m_nbyp >= MB || debug_req_i || !en_i;
      if (!rel && issue_entry_valid_i &&
          may_overtake(issue_entry_i, is_ctrl_flow_i, m_slot)) begin
        e_byp = 1; e_valid = 1; e_ack = issue_instr_ack_i;
      end else begin
        e_valid = 1; e_entry = m_slot; e_cf = m_slot_cf;
      end
    end
  endfunction

  task automatic advance();
    @(posedge clk_i);
    if (rst_i) begin
      m_parked = 0; m_shown = 0; m_age = 0; m_nbyp = 0; m_cnt = '0;
    end else if (flush_i) begin
      m_parked = 0; m_shown = 0;
    end else if (e_park) begin
      m_parked = 1; m_shown = 0; m_age = 0; m_nbyp = 0;
      m_slot = issue_entry_i; m_slot_cf = is_ctrl_flow_i;
    end else if (m_parked) begin
      if (m_age < 255) m_age++;
      if (e_byp) begin
        if (issue_instr_ack_i) begin
          m_nbyp++; m_cnt = m_cnt + 1;
        end
      end else if (issue_instr_ack_i) begin
        m_parked = 0; m_shown = 0;
      end else begin
        m_shown = 1;
      end
    end
    #1;
  endtask

  task automatic apply(step_t s);
    @(negedge clk_i);
    rst_i = s.rst; flush_i = s.flush; debug_req_i = s.dbg;
    en_i = s.en; lsu_ready_i = s.rdy;
    issue_entry_valid_i = s.vld; is_ctrl_flow_i = s.cf;
    issue_instr_ack_i = s.ack; issue_entry_i = s.e;
    #1;
    predict();
  endtask

  function automatic logic [VW-1:0] expv();
    scoreboard_entry_t ee;
    ee = e_valid ? e_entry : '0;
    return {e_ack, e_valid, e_held, e_cnt, e_valid & e_cf, ee};
  endfunction

  function automatic logic [VW-1:0] obs();
    scoreboard_entry_t oe;
    oe = e_valid ? issue_entry_o : '0;
    return {issue_instr_ack_o, issue_entry_valid_o, held_o,
            bypass_cnt_o, e_valid & is_ctrl_flow_o, oe};
  endfunction

  function automatic scoreboard_entry_t op(fu_t f, int rd,
                                           int rs1, int rs2);
    scoreboard_entry_t x;
    x.pc = $urandom; x.fu = f; x.op = 7'($urandom);
    x.rd = 5'(rd); x.rs1 = 5'(rs1); x.rs2 = 5'(rs2);
    x.result = $urandom;
    return x;
  endfunction

  function automatic step_t st(scoreboard_entry_t e, bit vld,
                               bit ack, bit rdy);
    step_t s;
    s = '0; s.en = 1; s.vld = vld; s.ack = ack; s.rdy = rdy; s.e = e;
    return s;
  endfunction

  function automatic step_t rst_step();
    step_t s;
    s = st(op(ALU, 1, 1, 1), 1, 1, 1);
    s.rst = 1;
    return s;
  endfunction

  task automatic test_reset();
    step_t q[$];
    q.push_back(rst_step());
    q.push_back(rst_step());
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL reset[%0d] got=%h want=%h", i, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_passthrough();
    step_t q[$];
    q.push_back(st(op(ALU, 6, 1, 2), 1, 1, 1));
    q.push_back(st(op(MULT, 3, 4, 5), 1, 0, 1));
    q.push_back(st(op(LOAD, 7, 1, 0), 1, 1, 1));
    q.push_back(st(op(ALU, 2, 2, 2), 0, 1, 0));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL passthrough[%0d] got=%h want=%h",
                 i, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_park_bypass();
    step_t q[$];
    q.push_back(rst_step());
    q.push_back(st(op(LOAD, 5, 1, 0), 1, 0, 0));
    q.push_back(st(op(ALU, 6, 1, 2), 1, 1, 0));
    q.push_back(st(op(ALU, 9, 9, 9), 0, 1, 1));
    q.push_back(st(op(ALU, 9, 9, 9), 0, 0, 1));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL park_bypass[%0d] got=%h want=%h",
                 i, obs(), expv());
      end
      advance();
    end
    total++;
    if (bypass_cnt_o !== 32'd1 || held_o !== 1'b0) begin
      bad++;
      $display("FAIL park_bypass_end got cnt=%0d held=%b want 1 0",
               bypass_cnt_o, held_o);
    end
  endtask

  task automatic test_dependency();
    step_t q[$];
    q.push_back(rst_step());
    q.push_back(st(op(LOAD, 5, 1, 0), 1, 0, 0));
    q.push_back(st(op(ALU, 7, 5, 1), 1, 0, 0));
    q.push_back(st(op(ALU, 7, 5, 1), 1, 0, 0));
    q.push_back(st(op(ALU, 7, 5, 1), 1, 1, 0));
    q.push_back(st(op(ALU, 7, 5, 1), 1, 1, 0));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL dependency[%0d] got=%h want=%h",
                 i, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_limits();
    step_t q[$];
    int n_over = 0;
    int n_wait = 0;
    q.push_back(rst_step());
    q.push_back(st(op(LOAD, 5, 1, 0), 1, 0, 0));
    for (int k = 0; k < 6; k++)
      q.push_back(st(op(ALU, 6 + k, 2, 3), 1, 1, 0));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL limit_bypass[%0d] got=%h want=%h",
                 i, obs(), expv());
      end
      if (held_o && issue_entry_valid_o && issue_instr_ack_i &&
          issue_entry_o.fu == ALU) n_over++;
      advance();
    end
    total++;
    if (n_over !== MB) begin
      bad++;
      $display("FAIL limit_bypass_count got=%0d want=%0d", n_over, MB);
    end
    q.delete();
    q.push_back(st(op(LOAD, 5, 1, 0), 1, 0, 0));
    for (int k = 0; k < 12; k++)
      q.push_back(st(op(ALU, 6, 2, 3), 1, 0, 0));
    q.push_back(st(op(ALU, 6, 2, 3), 1, 1, 0));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL limit_hold[%0d] got=%h want=%h",
                 i, obs(), expv());
      end
      if (held_o && issue_entry_valid_o &&
          issue_entry_o.fu == ALU) n_wait++;
      advance();
    end
    total++;
    if (n_wait !== MH) begin
      bad++;
      $display("FAIL limit_hold_count got=%0d want=%0d", n_wait, MH);
    end
  endtask

  task automatic test_flush();
    step_t q[$];
    step_t s;
    int n_store = 0;
    q.push_back(rst_step());
    q.push_back(st(op(STORE, 0, 2, 8), 1, 0, 0));
    q.push_back(st(op(ALU, 6, 1, 3), 1, 1, 0));
    s = st(op(ALU, 7, 1, 3), 1, 1, 0);
    s.flush = 1;
    q.push_back(s);
    q.push_back(st(op(ALU, 7, 1, 3), 0, 0, 1));
    q.push_back(st(op(ALU, 7, 1, 3), 0, 0, 1));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL flush[%0d] got=%h want=%h", i, obs(), expv());
      end
      if (issue_entry_valid_o && issue_entry_o.fu == STORE) n_store++;
      advance();
    end
    total++;
    if (n_store !== 0 || bypass_cnt_o !== 32'd1 || held_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_end got st=%0d cnt=%0d held=%b want 0 1 0",
               n_store, bypass_cnt_o, held_o);
    end
  endtask

  task automatic test_debug_reset();
    step_t q[$];
    step_t s;
    q.push_back(rst_step());
    q.push_back(st(op(LOAD, 5, 1, 0), 1, 0, 0));
    s = st(op(ALU, 6, 2, 3), 1, 0, 0);
    s.dbg = 1;
    q.push_back(s);
    q.push_back(st(op(ALU, 6, 2, 3), 1, 0, 0));
    s = st(op(ALU, 6, 2, 3), 1, 1, 0);
    s.rst = 1;
    q.push_back(s);
    q.push_back(st(op(ALU, 6, 2, 3), 0, 0, 0));
    q.push_back(st(op(ALU, 6, 2, 3), 1, 1, 1));
    foreach (q[i]) begin
      apply(q[i]);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL debug_reset[%0d] got=%h want=%h",
                 i, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_random();
    fu_t fl [10];
    step_t s;
    fl = '{NONE, LOAD, STORE, ALU, ALU, MULT,
           CTRL_FLOW, CSR, FPU, FPU_VEC};
    apply(rst_step());
    advance();
    for (int i = 0; i < 3000; i++) begin
      s = st(op(fl[$urandom_range(9)], $urandom_range(7),
                $urandom_range(7), $urandom_range(7)),
             $urandom_range(99) < 85, $urandom_range(99) < 60,
             $urandom_range(99) < 35);
      s.rst   = $urandom_range(199) == 0;
      s.flush = $urandom_range(99) < 4;
      s.dbg   = $urandom_range(99) < 6;
      s.en    = $urandom_range(99) < 92;
      s.cf    = $urandom_range(99) < 8;
      apply(s);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs(), expv());
      end
      advance();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_park_bypass();
    test_dependency();
    test_limits();
    test_flush();
    test_debug_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
